// File: rtl/if_id_skid_pkg.sv
// Shared types for the IF->ID skid register: occupancy state encoding, default widths,
// and the two decode helpers that turn the occupancy state into handshake outputs.
package if_id_skid_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int INST_W_DEF = 32;
   localparam int CNT_W_DEF  = 16;

   // 2'd3 is unused; the next-state logic steers it back to EMPTY.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } ifid_state_t;

   function automatic logic state_accepts(input ifid_state_t s);
      return (s != ST_SKID);
   endfunction

   function automatic logic state_presents(input ifid_state_t s);
      return (s == ST_FULL) || (s == ST_SKID);
   endfunction

endpackage

// File: rtl/if_id_skid_if.sv
// Valid/ready beat carrying a pc and an instruction; master drives the beat, slave answers ready.
interface if_id_skid_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);
   logic              valid;
   logic              ready;
   logic [ADDR_W-1:0] pc;
   logic [INST_W-1:0] inst;

   modport master (output valid, output pc, output inst, input ready);
   modport slave  (input valid, input pc, input inst, output ready);
endinterface

// File: rtl/if_id_skid_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; reusable for performance counters.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + CNT_ONE;
      end
   end

endmodule

// File: rtl/if_id_skid.sv
// IF->ID pipeline register with a one-entry skid so if_ready is a pure register, plus flush
// and a saturating count of cycles in which ID saw no valid beat.
module if_id_skid
   import if_id_skid_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int INST_W = INST_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   if_id_skid_if.slave      fetch,
   if_id_skid_if.master     decode,
   output logic [CNT_W-1:0] bubble_cnt
);

   ifid_state_t       state, state_nxt;
   logic [ADDR_W-1:0] main_pc, main_pc_nxt, skid_pc, skid_pc_nxt;
   logic [INST_W-1:0] main_inst, main_inst_nxt, skid_inst, skid_inst_nxt;
   logic              id_valid_r, if_ready_r;
   logic              in_fire, out_fire;

   assign in_fire  = fetch.valid & if_ready_r;
   assign out_fire = id_valid_r & decode.ready;

   // NOTE: every always_comb target gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt     = state;
      main_pc_nxt   = main_pc;
      main_inst_nxt = main_inst;
      skid_pc_nxt   = skid_pc;
      skid_inst_nxt = skid_inst;

      if (flush) begin
         // A beat consumed by ID this cycle is already gone; everything else is squashed.
         state_nxt     = ST_EMPTY;
         main_pc_nxt   = '0;
         main_inst_nxt = '0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_nxt     = ST_FULL;
                  main_pc_nxt   = fetch.pc;
                  main_inst_nxt = fetch.inst;
               end
            end
            ST_FULL: begin
               if (in_fire && out_fire) begin
                  main_pc_nxt   = fetch.pc;
                  main_inst_nxt = fetch.inst;
               end else if (in_fire) begin
                  state_nxt     = ST_SKID;
                  skid_pc_nxt   = fetch.pc;
                  skid_inst_nxt = fetch.inst;
               end else if (out_fire) begin
                  state_nxt     = ST_EMPTY;
                  main_pc_nxt   = '0;
                  main_inst_nxt = '0;
               end
            end
            ST_SKID: begin
               if (out_fire) begin
                  state_nxt     = ST_FULL;
                  main_pc_nxt   = skid_pc;
                  main_inst_nxt = skid_inst;
               end
            end
            default: begin
               state_nxt     = ST_EMPTY;
               main_pc_nxt   = '0;
               main_inst_nxt = '0;
            end
         endcase
      end
   end

   // Handshake outputs are decoded from the next state so they leave the block as flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_EMPTY;
         main_pc    <= '0;
         main_inst  <= '0;
         skid_pc    <= '0;
         skid_inst  <= '0;
         id_valid_r <= 1'b0;
         if_ready_r <= 1'b1;
      end else begin
         state      <= state_nxt;
         main_pc    <= main_pc_nxt;
         main_inst  <= main_inst_nxt;
         skid_pc    <= skid_pc_nxt;
         skid_inst  <= skid_inst_nxt;
         id_valid_r <= state_presents(state_nxt);
         if_ready_r <= state_accepts(state_nxt);
      end
   end

   assign fetch.ready  = if_ready_r;
   assign decode.valid = id_valid_r;
   assign decode.pc    = main_pc;
   assign decode.inst  = main_inst;

   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (~id_valid_r),
      .count (bubble_cnt)
   );

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: a queue-of-beats reference checked every cycle, directed scenarios
// with literal expectations, randomized traffic, and a narrow-counter instance for saturation.
module tb_if_id_skid;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [15:0] bubble_cnt;
   logic [3:0]  sat_cnt;

   always #5 clk = ~clk;

   if_id_skid_if #(.ADDR_W(32), .INST_W(32)) fetch ();
   if_id_skid_if #(.ADDR_W(32), .INST_W(32)) decode ();
   if_id_skid_if #(.ADDR_W(32), .INST_W(32)) sat_fetch ();
   if_id_skid_if #(.ADDR_W(32), .INST_W(32)) sat_decode ();

   if_id_skid #(.ADDR_W(32), .INST_W(32), .CNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .fetch      (fetch),
      .decode     (decode),
      .bubble_cnt (bubble_cnt)
   );

   // Always idle, so its bubble counter climbs every cycle and must stop at 15.
   if_id_skid #(.ADDR_W(32), .INST_W(32), .CNT_W(4)) dut_sat (
      .clk        (clk),
      .rst        (rst),
      .flush      (1'b0),
      .fetch      (sat_fetch),
      .decode     (sat_decode),
      .bubble_cnt (sat_cnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: the block is a FIFO of at most two beats; the head is what ID sees.
   logic [31:0] q_pc[$];
   logic [31:0] q_inst[$];
   int unsigned cnt_m   = 0;
   int unsigned sat_m   = 0;
   bit          started = 1'b0;

   always @(posedge clk) begin : model
      bit in_f, out_f;
      in_f  = (fetch.valid === 1'b1) && (q_pc.size() < 2);
      out_f = (q_pc.size() > 0) && (decode.ready === 1'b1);
      if (rst) begin
         q_pc.delete();
         q_inst.delete();
         cnt_m   = 0;
         sat_m   = 0;
         started = 1'b1;
      end else begin
         if (q_pc.size() == 0 && cnt_m < 65535) cnt_m++;
         if (sat_m < 15) sat_m++;
         if (out_f) begin
            void'(q_pc.pop_front());
            void'(q_inst.pop_front());
         end
         if (flush) begin
            q_pc.delete();
            q_inst.delete();
         end else if (in_f) begin
            q_pc.push_back(fetch.pc);
            q_inst.push_back(fetch.inst);
         end
      end
   end

   always @(negedge clk) begin : compare
      if (started) begin
         check("id_valid",   32'(decode.valid), 32'(q_pc.size() > 0));
         check("if_ready",   32'(fetch.ready),  32'(q_pc.size() < 2));
         check("id_pc",      decode.pc,   (q_pc.size() > 0) ? q_pc[0]   : 32'h0);
         check("id_inst",    decode.inst, (q_inst.size() > 0) ? q_inst[0] : 32'h0);
         check("bubble_cnt", 32'(bubble_cnt), cnt_m);
         check("sat_cnt",    32'(sat_cnt),    sat_m);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic rdy, input logic fl);
      fetch.valid  = v;
      fetch.pc     = pc;
      fetch.inst   = inst;
      decode.ready = rdy;
      flush        = fl;
   endtask

   initial begin
      bit pending;
      logic [31:0] next_pc;

      sat_fetch.valid  = 1'b0;
      sat_fetch.pc     = '0;
      sat_fetch.inst   = '0;
      sat_decode.ready = 1'b1;

      // Reset held two cycles while IF keeps offering a beat.
      rst = 1'b1;
      drive(1'b1, 32'h100, 32'hdead, 1'b1, 1'b0);
      tick();
      tick();
      check("rst_id_valid",   32'(decode.valid), 32'h0);
      check("rst_id_pc",      decode.pc,         32'h0);
      check("rst_id_inst",    decode.inst,       32'h0);
      check("rst_if_ready",   32'(fetch.ready),  32'h1);
      check("rst_bubble_cnt", 32'(bubble_cnt),   32'h0);
      rst = 1'b0;

      // 20 idle cycles: wide counter reaches 20, narrow one pins at 15 and stays there.
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      repeat (20) tick();
      check("idle_bubble_cnt", 32'(bubble_cnt), 32'd20);
      check("sat_cnt_15",      32'(sat_cnt),    32'd15);
      repeat (3) tick();
      check("sat_cnt_held",    32'(sat_cnt),    32'd15);

      // Back-to-back streaming with ID always ready.
      drive(1'b1, 32'h0, 32'h11, 1'b1, 1'b0);
      tick();
      check("stream_pc0",   decode.pc,   32'h0);
      check("stream_inst0", decode.inst, 32'h11);
      drive(1'b1, 32'h4, 32'h22, 1'b1, 1'b0);
      tick();
      check("stream_pc1",   decode.pc,   32'h4);
      check("stream_inst1", decode.inst, 32'h22);
      drive(1'b1, 32'h8, 32'h33, 1'b1, 1'b0);
      tick();
      check("stream_pc2",    decode.pc,         32'h8);
      check("stream_inst2",  decode.inst,       32'h33);
      check("stream_ready",  32'(fetch.ready),  32'h1);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      check("stream_drain",  32'(decode.valid), 32'h0);

      // Stall: second beat lands in the skid entry and if_ready drops.
      drive(1'b1, 32'h4, 32'h44, 1'b0, 1'b0);
      tick();
      check("stall_full_pc", decode.pc, 32'h4);
      drive(1'b1, 32'h8, 32'h88, 1'b0, 1'b0);
      tick();
      check("stall_skid_ready", 32'(fetch.ready), 32'h0);
      check("stall_skid_pc",    decode.pc,        32'h4);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      check("release_pc",   decode.pc,   32'h8);
      check("release_inst", decode.inst, 32'h88);
      tick();
      check("release_empty", 32'(decode.valid), 32'h0);

      // Flush while SKID and while IF offers 0xC: nothing held may surface afterwards.
      drive(1'b1, 32'h4, 32'h44, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h8, 32'h88, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'hc, 32'hcc, 1'b0, 1'b1);
      tick();
      check("flush_valid", 32'(decode.valid), 32'h0);
      check("flush_inst",  decode.inst,       32'h0);
      check("flush_pc",    decode.pc,         32'h0);
      check("flush_ready", 32'(fetch.ready),  32'h1);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      repeat (3) tick();
      check("flush_stays_empty", 32'(decode.valid), 32'h0);

      // Randomized traffic; an offered beat is held stable until the block accepts it.
      pending = 1'b0;
      next_pc = 32'h1000;
      for (int i = 0; i < 3000; i++) begin
         if (!pending) begin
            fetch.valid = ($urandom_range(0, 3) != 0);
            fetch.pc    = next_pc;
            fetch.inst  = $urandom;
            next_pc     = next_pc + 32'd4;
         end
         decode.ready = $urandom_range(0, 1) == 1;
         flush        = ($urandom_range(0, 31) == 0);
         rst          = ($urandom_range(0, 399) == 0);
         pending      = fetch.valid && (q_pc.size() == 2) && !flush && !rst;
         tick();
      end
      rst   = 1'b0;
      flush = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
